// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    localparam int DEFAULT_CLOCKS_PER_PULSE = 4;
    localparam int DEFAULT_DATA_WIDTH       = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser; resets to the idle-high line level.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver: mid-bit sampling, stop-bit check, sticky ready/overrun.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = DEFAULT_CLOCKS_PER_PULSE,
    parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    input  logic                  ready_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int HALF  = CLOCKS_PER_PULSE / 2;
    localparam int CNT_W = $clog2(CLOCKS_PER_PULSE);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    logic                  w_rx_s;

    rx_state_t             r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_ready;
    logic                  r_ferr;
    logic                  r_ovr;
    logic                  r_busy;

    rx_state_t             w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic                  w_ready_nxt;
    logic                  w_ferr_nxt;
    logic                  w_ovr_nxt;
    logic [DATA_WIDTH:0]   w_cat;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    assign w_cat = {w_rx_s, r_shift};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_ready <= w_ready_nxt;
            r_ferr  <= w_ferr_nxt;
            r_ovr   <= w_ovr_nxt;
            r_busy  <= (w_state_nxt != RX_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_ready_nxt = r_ready & ~ready_clr;
        w_ovr_nxt   = r_ovr & ~ready_clr;
        w_ferr_nxt  = r_ferr;

        case (r_state)
            RX_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = RX_START;
                    w_cnt_nxt   = '0;
                end
            end
            RX_START: begin
                if (r_cnt == CNT_HALF) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = '0;
                    w_state_nxt = w_rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_shift_nxt = w_cat[DATA_WIDTH:1];
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    if (r_idx == IDX_LAST) begin
                        w_state_nxt = RX_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RX_WAIT_IDLE;
                    if (w_rx_s) begin
                        w_data_nxt  = r_shift;
                        w_ready_nxt = 1'b1;
                        w_ferr_nxt  = 1'b0;
                        // A concurrent clear consumes the old byte, so no overrun.
                        if (r_ready && !ready_clr) begin
                            w_ovr_nxt = 1'b1;
                        end
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RX_WAIT_IDLE: begin
                if (w_rx_s) begin
                    w_state_nxt = RX_IDLE;
                end
            end
            default: begin
                w_state_nxt = RX_IDLE;
            end
        endcase
    end

    assign data_out  = r_data;
    assign ready     = r_ready;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;
    assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os with directed 8N1 frames.
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready_clr = 1'b0;
    logic [7:0] data_out;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_os #(
        .CLOCKS_PER_PULSE (4),
        .DATA_WIDTH       (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .ready_clr (ready_clr),
        .data_out  (data_out),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       rdy;
        logic       ferr;
        logic       ovr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Call just after a posedge; that next edge is frame edge 1.
    task automatic send(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(4);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(4);
        end
        rx = stop;
        tick(4);
        rx = 1'b1;
    endtask

    task automatic clr();
        ready_clr = 1'b1;
        tick(1);
        ready_clr = 1'b0;
    endtask

    task automatic expect_ev(input logic [7:0] d, input logic r,
                             input logic f, input logic o);
        exp_t e;
        e.data = d;
        e.rdy  = r;
        e.ferr = f;
        e.ovr  = o;
        sb_q.push_back(e);
    endtask

    logic [7:0] p_data;
    logic       p_rdy;
    logic       p_ferr;
    logic       p_ovr;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ((ready && !p_rdy) || (data_out !== p_data) ||
                     (overrun && !p_ovr) || (frame_err && !p_ferr))) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got data=%0h ready=%0b ferr=%0b ovr=%0b required no event",
                         data_out, ready, frame_err, overrun);
            end else begin
                e = sb_q.pop_front();
                check("sb_data", 32'(data_out), 32'(e.data));
                check("sb_ready", 32'(ready), 32'(e.rdy));
                check("sb_ferr", 32'(frame_err), 32'(e.ferr));
                check("sb_ovr", 32'(overrun), 32'(e.ovr));
            end
        end
        p_data <= data_out;
        p_rdy  <= ready;
        p_ferr <= frame_err;
        p_ovr  <= overrun;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        tick(3);
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick(3);

        // 1: clean 0xA5 with edge-exact timing
        expect_ev(8'hA5, 1'b1, 1'b0, 1'b0);
        send(8'hA5, 1'b1);
        check("s1_ready_e40", 32'(ready), 32'h0);
        tick(1);
        check("s1_ready_e41", 32'(ready), 32'h1);
        check("s1_busy_e41", 32'(busy), 32'h1);
        tick(1);
        check("s1_busy_e42", 32'(busy), 32'h0);
        clr();
        check("s1_clr", 32'(ready), 32'h0);
        tick(2);

        // 2: one-clock glitch
        seen = 1'b0;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (busy) seen = 1'b1;
        end
        check("s2_busy_seen", 32'(seen), 32'h1);
        check("s2_busy_end", 32'(busy), 32'h0);
        check("s2_ready", 32'(ready), 32'h0);
        check("s2_ferr", 32'(frame_err), 32'h0);

        // 3: bad stop bit, then a good frame
        expect_ev(8'hA5, 1'b0, 1'b1, 1'b0);
        send(8'h3C, 1'b0);
        tick(4);
        check("s3_busy", 32'(busy), 32'h0);
        expect_ev(8'h11, 1'b1, 1'b0, 1'b0);
        send(8'h11, 1'b1);
        tick(2);
        clr();
        tick(2);

        // 4: back-to-back frames without clearing
        expect_ev(8'h01, 1'b1, 1'b0, 1'b0);
        expect_ev(8'h02, 1'b1, 1'b0, 1'b1);
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        tick(2);
        clr();
        check("s4_clr_ready", 32'(ready), 32'h0);
        check("s4_clr_ovr", 32'(overrun), 32'h0);
        check("s4_data", 32'(data_out), 32'h02);
        tick(2);

        // 5: reset during data bit 3 of 0xFF
        rx = 1'b0;
        tick(4);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            tick(4);
        end
        rx = 1'b1;
        tick(2);
        #1 rst = 1'b1;
        #1;
        check("s5_rst_data", 32'(data_out), 32'h0);
        check("s5_rst_ready", 32'(ready), 32'h0);
        check("s5_rst_busy", 32'(busy), 32'h0);
        tick(2);
        rst = 1'b0;
        tick(50);
        check("s5_no_partial", 32'(data_out), 32'h0);
        check("s5_no_ready", 32'(ready), 32'h0);
        expect_ev(8'h5A, 1'b1, 1'b0, 1'b0);
        send(8'h5A, 1'b1);
        tick(2);
        clr();
        tick(2);

        // 6: clear coincident with the stop sample
        expect_ev(8'h7E, 1'b1, 1'b0, 1'b0);
        send(8'h7E, 1'b1);
        ready_clr = 1'b1;
        tick(1);
        ready_clr = 1'b0;
        check("s6_ready", 32'(ready), 32'h1);
        check("s6_ovr", 32'(overrun), 32'h0);
        check("s6_data", 32'(data_out), 32'h7E);
        tick(3);

        check("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
